// File: rtl/cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_phase_sequencer
//  Description : Multi-cycle control sequencer for the 8-bit accumulator CPU.
//                Steps each instruction through eight fixed phases and drives
//                the PC / IR / accumulator / memory / ALU enables. Also owns
//                program-load mode, halt/resume and a retired-instruction
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_phase_sequencer #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,       // asynchronous, active-low
    input  logic             i_load,
    input  logic             i_load_valid,
    input  logic             i_start,
    input  logic [2:0]       i_opcode,
    input  logic             i_acc_zero,
    output logic             o_sel,
    output logic             o_rd,
    output logic             o_ld_ir,
    output logic             o_inc_pc,
    output logic             o_ld_pc,
    output logic             o_pc_clr,
    output logic             o_ld_ac,
    output logic             o_data_e,
    output logic             o_wr,
    output logic [2:0]       o_alu_op,
    output logic             o_load_we,
    output logic             o_load_full,
    output logic [2:0]       o_phase,
    output logic             o_busy,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_retired
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_OP_HLT = 3'd0;
    localparam logic [2:0] c_OP_SKZ = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_AND = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_LDA = 3'd5;
    localparam logic [2:0] c_OP_STO = 3'd6;
    localparam logic [2:0] c_OP_JMP = 3'd7;

    // Load depth 2**ADDR_W, held in a counter one bit wider than the PC
    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_phase;
    logic [2:0]        w_phase_nxt;
    logic [ADDR_W:0]   r_load_cnt;
    logic              r_load_first;
    logic [CNT_W-1:0]  r_retired;

    logic              w_op_hlt;
    logic              w_op_skz;
    logic              w_op_sto;
    logic              w_op_jmp;
    logic              w_op_alu;
    logic              w_load_full;
    logic              w_load_we;
    logic              w_retire;
    logic              w_cold_start;

    // ------------------------------------------------------------------------
    // Opcode decode (IR output is stable from phase 4 onward)
    // ------------------------------------------------------------------------
    assign w_op_hlt = (i_opcode == c_OP_HLT);
    assign w_op_skz = (i_opcode == c_OP_SKZ);
    assign w_op_sto = (i_opcode == c_OP_STO);
    assign w_op_jmp = (i_opcode == c_OP_JMP);
    assign w_op_alu = (i_opcode == c_OP_ADD) || (i_opcode == c_OP_AND) ||
                      (i_opcode == c_OP_XOR) || (i_opcode == c_OP_LDA);

    // Load-mode write strobe: the first LOAD cycle is reserved for the PC clear
    assign w_load_full = (r_load_cnt == c_DEPTH);
    assign w_load_we   = (r_state == S_LOAD) && !r_load_first &&
                         i_load_valid && !w_load_full;

    // An instruction retires at the instruction boundary (end of phase 7)
    assign w_retire     = (r_state == S_RUN) && (r_phase == 3'd7);
    // Starting from IDLE is a cold start: PC and retired count restart
    assign w_cold_start = (r_state == S_IDLE) && i_start && !i_load;

    // State and phase register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_phase <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Flag marking the first cycle spent in LOAD
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_load_first <= 1'b0;
        end else begin
            r_load_first <= (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
        end
    end

    // Load word counter: counts write strobes, cleared whenever LOAD is not held
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_load_cnt <= '0;
        end else if ((r_state != S_LOAD) || (w_state_nxt != S_LOAD)) begin
            r_load_cnt <= '0;
        end else if (w_load_we) begin
            r_load_cnt <= r_load_cnt + (ADDR_W+1)'(1);
        end
    end

    // Retired-instruction counter, wrapping naturally at 2**CNT_W
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_retired <= '0;
        end else if (w_cold_start) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Next-state logic and per-state / per-phase control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        o_sel       = 1'b0;
        o_rd        = 1'b0;
        o_ld_ir     = 1'b0;
        o_inc_pc    = 1'b0;
        o_ld_pc     = 1'b0;
        o_pc_clr    = 1'b0;
        o_ld_ac     = 1'b0;
        o_data_e    = 1'b0;
        o_wr        = 1'b0;
        o_alu_op    = 3'd0;
        o_halted    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_phase_nxt = 3'd0;
                if (i_load) begin
                    w_state_nxt = S_LOAD;
                end else if (i_start) begin
                    w_state_nxt = S_RUN;
                    o_pc_clr    = 1'b1;
                end
            end

            S_LOAD: begin
                w_phase_nxt = 3'd0;
                o_sel       = 1'b1;
                o_pc_clr    = r_load_first;
                o_inc_pc    = w_load_we;   // PC doubles as the write pointer
                if (!i_load) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_RUN: begin
                // Phase sequencing; HLT and load requests only act at fixed points
                if ((r_phase == 3'd4) && w_op_hlt) begin
                    w_state_nxt = S_HALT;
                    w_phase_nxt = 3'd4;
                end else if (r_phase == 3'd7) begin
                    w_phase_nxt = 3'd0;
                    if (i_load) begin
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    w_phase_nxt = r_phase + 3'd1;
                end

                case (r_phase)
                    3'd0: begin
                        o_sel = 1'b1;
                    end
                    3'd1: begin
                        o_sel = 1'b1;
                        o_rd  = 1'b1;
                    end
                    3'd2, 3'd3: begin
                        o_sel   = 1'b1;
                        o_rd    = 1'b1;
                        o_ld_ir = 1'b1;
                    end
                    3'd4: begin
                        o_inc_pc = 1'b1;
                        o_halted = w_op_hlt;
                    end
                    3'd5: begin
                        o_rd     = w_op_alu;
                        o_alu_op = w_op_alu ? i_opcode : 3'd0;
                    end
                    3'd6: begin
                        o_rd     = w_op_alu;
                        o_alu_op = w_op_alu ? i_opcode : 3'd0;
                        o_inc_pc = w_op_skz && i_acc_zero;
                        o_ld_pc  = w_op_jmp;
                        o_data_e = w_op_sto;
                    end
                    default: begin  // phase 7
                        o_rd     = w_op_alu;
                        o_ld_ac  = w_op_alu;
                        o_alu_op = w_op_alu ? i_opcode : 3'd0;
                        o_ld_pc  = w_op_jmp;
                        o_data_e = w_op_sto;
                        o_wr     = w_op_sto;
                    end
                endcase
            end

            default: begin  // S_HALT: phase parked at 4, resume keeps the PC
                o_halted    = 1'b1;
                if (i_load) begin
                    w_state_nxt = S_LOAD;
                    w_phase_nxt = 3'd0;
                end else if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_phase_nxt = 3'd0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    assign o_load_we   = w_load_we;
    assign o_load_full = w_load_full;
    assign o_phase     = r_phase;
    assign o_busy      = (r_state == S_RUN);
    assign o_retired   = r_retired;

endmodule
`default_nettype wire
